// File: rtl/systolic_ctrl_pkg.sv
// Shared types and helpers for the systolic array controller.
// Holds the FSM state enum, the tag word carried down the result delay line,
// and the default pipeline-latency helper (array rows + columns).
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LATCH_W = 3'd2,
        STREAM  = 3'd3,
        DRAIN   = 3'd4,
        FIN     = 3'd5
    } state_t;

    // Per-vector tag travelling alongside the array datapath.
    typedef struct packed {
        logic vld;
        logic last;
    } tag_t;

    // A vector entering the array corner needs M+N cycles to reach the output edge.
    function automatic int default_pipe_lat(input int array_m, input int array_n);
        return array_m + array_n;
    endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Handshake/strobe bundle between the controller and the array + data sources.
// Ports: wgt_valid/wgt_ready weight beats, b_path_en/b_en weight shift/latch strobes,
//        inp_valid/inp_ready input vectors, out_valid/out_last result qualifiers.
interface systolic_ctrl_if #(
    parameter int ARRAY_M = 32
);
    logic               wgt_valid;
    logic               wgt_ready;
    logic [ARRAY_M-1:0] b_path_en;
    logic [ARRAY_M-1:0] b_en;
    logic               inp_valid;
    logic               inp_ready;
    logic               out_valid;
    logic               out_last;

    // Controller side.
    modport master (
        input  wgt_valid,
        input  inp_valid,
        output wgt_ready,
        output b_path_en,
        output b_en,
        output inp_ready,
        output out_valid,
        output out_last
    );

    // Array / data-source side.
    modport slave (
        output wgt_valid,
        output inp_valid,
        input  wgt_ready,
        input  b_path_en,
        input  b_en,
        input  inp_ready,
        input  out_valid,
        input  out_last
    );
endinterface

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register carrying {valid,last} tags alongside the array.
// Latency: DEPTH cycles from din_i to dout_o. No backpressure: shifts every cycle.
// Ports: clk, rst (sync, active-high, clears every stage), din_i, dout_o.
module valid_delay_line #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] din_i,
    output logic [1:0] dout_o
);

    logic [1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= 2'b00;
            end
        end else begin
            pipe_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for a weight-stationary systolic array: load weights, latch, stream, drain.
// Latency: result valid PIPE_LAT cycles after each accepted input vector; done 1 cycle after out_last.
// Backpressure: wgt/inp valid=0 stalls the load/stream phase; readies come from state only.
// Ports: clk, rst (sync active-high), start/k_len job request, busy/done status,
//        bus (systolic_ctrl_if.master) weight/input handshakes, array strobes, result qualifiers.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int ARRAY_M   = 32,
    parameter int ARRAY_N   = 32,
    parameter int LEN_WIDTH = 16,
    parameter int PIPE_LAT  = default_pipe_lat(ARRAY_M, ARRAY_N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] k_len,
    output logic                 busy,
    output logic                 done,
    systolic_ctrl_if.master      bus
);

    localparam int BEAT_W = $clog2(ARRAY_N) + 1;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] klen_q, klen_d;
    logic [LEN_WIDTH-1:0] vcnt_q, vcnt_d;
    logic [BEAT_W-1:0]    bcnt_q, bcnt_d;

    logic wgt_hs;
    logic inp_hs;
    logic last_acc;
    tag_t tag_in;
    tag_t tag_out;

    // Readies depend only on state_q, so these handshakes never loop valid back into ready.
    assign wgt_hs   = bus.wgt_valid & (state_q == LOAD_W);
    assign inp_hs   = bus.inp_valid & (state_q == STREAM);
    // k_len is nonzero whenever STREAM is entered, so k_len-1 never underflows here.
    assign last_acc = inp_hs & (vcnt_q == (klen_q - LEN_WIDTH'(1)));

    // Bubbles enter the delay line as an all-zero tag.
    assign tag_in = '{vld: inp_hs, last: last_acc};

    valid_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_dly (
        .clk    (clk),
        .rst    (rst),
        .din_i  (tag_in),
        .dout_o (tag_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            klen_q  <= '0;
            vcnt_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            vcnt_q  <= vcnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        klen_d        = klen_q;
        vcnt_d        = vcnt_q;
        bcnt_d        = bcnt_q;

        busy          = (state_q != IDLE);
        done          = (state_q == FIN);
        bus.wgt_ready = (state_q == LOAD_W);
        bus.inp_ready = (state_q == STREAM);
        bus.b_path_en = {ARRAY_M{wgt_hs}};
        bus.b_en      = {ARRAY_M{state_q == LATCH_W}};
        bus.out_valid = tag_out.vld;
        bus.out_last  = tag_out.vld & tag_out.last;

        case (state_q)
            IDLE: begin
                if (start) begin
                    klen_d  = k_len;
                    vcnt_d  = '0;
                    bcnt_d  = '0;
                    state_d = LOAD_W;
                end
            end
            LOAD_W: begin
                if (wgt_hs) begin
                    bcnt_d = bcnt_q + BEAT_W'(1);
                    if (bcnt_q == BEAT_W'(ARRAY_N - 1)) begin
                        state_d = LATCH_W;
                    end
                end
            end
            LATCH_W: begin
                state_d = (klen_q != '0) ? STREAM : FIN;
            end
            STREAM: begin
                if (inp_hs) begin
                    vcnt_d = vcnt_q + LEN_WIDTH'(1);
                    if (last_acc) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (tag_out.vld & tag_out.last) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl (ARRAY_M=ARRAY_N=4, PIPE_LAT=8).
// The reference model turns a job's valid streams into an expected event timeline
// (beat cycles, latch cycle, acceptance cycles, result cycles, done cycle) and compares every cycle.
module tb_systolic_ctrl;

    localparam int M    = 4;
    localparam int N    = 4;
    localparam int LW   = 16;
    localparam int PL   = 8;
    localparam int MAXC = 400;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] k_len;
    logic          busy;
    logic          done;

    systolic_ctrl_if #(.ARRAY_M(M)) bus ();

    systolic_ctrl #(
        .ARRAY_M   (M),
        .ARRAY_N   (N),
        .LEN_WIDTH (LW),
        .PIPE_LAT  (PL)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .k_len (k_len),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit wv [MAXC];
    bit iv [MAXC];

    // Observed tallies of the most recent run_job, all times relative to the start cycle.
    int n_bp, n_ben, n_acc, n_ir, n_ov, n_last, n_done;
    int first_acc, first_ov, last_ov, last_t, last_bp_t, ben_t;

    function automatic logic [13:0] snap();
        return {busy, done, bus.wgt_ready, bus.inp_ready, bus.out_valid, bus.out_last,
                bus.b_path_en, bus.b_en};
    endfunction

    // Runs one job whose weight/input valid streams are wv[]/iv[] (index = cycle after start).
    // spur adds random start pulses and k_len changes while the job is busy.
    task automatic run_job(input int k, input bit spur, input string name);
        int          w4, fin, c, beats, got, last_acc;
        int          acc[$];
        bit          sv [MAXC];
        logic [13:0] exp_v, act_v;
        bit          e_wr, e_ir, e_ov, e_ol;

        n_bp = 0; n_ben = 0; n_acc = 0; n_ir = 0; n_ov = 0; n_last = 0; n_done = 0;
        first_acc = -1; first_ov = -1; last_ov = -1; last_t = -1; last_bp_t = -1; ben_t = -1;

        // Expected timeline: beats counted from cycle 1, vectors from 2 cycles after the last beat.
        c = 1; beats = 0; w4 = 0;
        while (beats < N && c < MAXC - 2*PL - 4) begin
            if (wv[c]) begin beats++; w4 = c; end
            c++;
        end
        got = 0;
        if (k > 0) begin
            c = w4 + 2;
            while (got < k && c < MAXC - 2*PL - 4) begin
                if (iv[c]) begin acc.push_back(c); got++; end
                c++;
            end
        end
        if (beats < N || got < k) begin
            total++; bad++;
            $display("FAIL %s stimulus_len: beats=%0d vectors=%0d required %0d/%0d", name, beats, got, N, k);
            return;
        end
        last_acc = (k > 0) ? acc[k-1] : -100;
        fin      = (k == 0) ? w4 + 2 : last_acc + PL + 1;

        for (int t = 0; t < MAXC; t++) sv[t] = 1'b0;
        if (spur) for (int t = 1; t <= fin; t++) sv[t] = ($urandom_range(0, 2) == 0);

        for (int t = 0; t <= fin + 2; t++) begin
            @(posedge clk); #1;
            start         = (t == 0) || sv[t];
            k_len         = (t == 0) ? LW'(k) : LW'($urandom);
            bus.wgt_valid = wv[t];
            bus.inp_valid = iv[t];
            @(negedge clk);

            e_wr = (t >= 1) && (t <= w4);
            e_ir = (k > 0) && (t >= w4 + 2) && (t <= last_acc);
            e_ov = 1'b0;
            foreach (acc[i]) if (acc[i] + PL == t) e_ov = 1'b1;
            e_ol = (k > 0) && (t == last_acc + PL);
            exp_v = {(t >= 1) && (t <= fin), t == fin, e_wr, e_ir, e_ov, e_ol,
                     {M{e_wr && wv[t]}}, {M{t == w4 + 1}}};
            act_v = snap();
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL %s cycle%0d {busy,done,wr,ir,ov,ol,bpe,ben}: got %b required %b",
                         name, t, act_v, exp_v);
            end

            if (bus.b_path_en == {M{1'b1}}) begin n_bp++; last_bp_t = t; end
            if (bus.b_en == {M{1'b1}}) begin n_ben++; ben_t = t; end
            if (bus.inp_ready) n_ir++;
            if (bus.inp_ready && bus.inp_valid) begin
                n_acc++;
                if (first_acc < 0) first_acc = t;
            end
            if (bus.out_valid) begin
                n_ov++; last_ov = t;
                if (first_ov < 0) first_ov = t;
            end
            if (bus.out_last) begin n_last++; last_t = t; end
            if (done) n_done++;
        end
        start = 1'b0;
        bus.wgt_valid = 1'b0;
        bus.inp_valid = 1'b0;
    endtask

    task automatic fill(input int wmode, input int imode);
        for (int i = 0; i < MAXC; i++) begin
            wv[i] = (wmode == 0) ? 1'b1 : (wmode == 1) ? bit'(i % 2) : bit'($urandom_range(0, 1));
            iv[i] = (imode == 0) ? 1'b1 : (imode == 1) ? 1'b0 : bit'($urandom_range(0, 1));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; k_len = 16'd5;
        bus.wgt_valid = 1'b1; bus.inp_valid = 1'b1;
        for (int t = 0; t < 5; t++) begin
            if (t == 3) begin
                @(posedge clk); #1;
                rst = 1'b0; start = 1'b0;
            end
            @(negedge clk);
            total++;
            if (snap() !== 14'd0) begin
                bad++;
                $display("FAIL reset_values cycle%0d: got %b required %b", t, snap(), 14'd0);
            end
        end
        bus.wgt_valid = 1'b0; bus.inp_valid = 1'b0;
    endtask

    task automatic test_full_job();
        fill(0, 0);
        run_job(3, 1'b0, "full");
        total++; if (n_bp !== 4)              begin bad++; $display("FAIL full_bpe_cycles: got %0d required 4", n_bp); end
        total++; if (n_ben !== 1)             begin bad++; $display("FAIL full_ben_cycles: got %0d required 1", n_ben); end
        total++; if (n_acc !== 3)             begin bad++; $display("FAIL full_accepts: got %0d required 3", n_acc); end
        total++; if (n_ov !== 3)              begin bad++; $display("FAIL full_out_valid: got %0d required 3", n_ov); end
        total++; if (first_ov - first_acc !== PL) begin bad++; $display("FAIL full_latency: got %0d required %0d", first_ov - first_acc, PL); end
        total++; if (last_t !== last_ov)      begin bad++; $display("FAIL full_last_pos: got %0d required %0d", last_t, last_ov); end
        total++; if (n_done !== 1)            begin bad++; $display("FAIL full_done: got %0d required 1", n_done); end
    endtask

    task automatic test_wgt_toggle();
        fill(1, 0);
        run_job(1, 1'b0, "toggle");
        total++; if (n_bp !== 4)          begin bad++; $display("FAIL toggle_bpe_pulses: got %0d required 4", n_bp); end
        total++; if (last_bp_t !== 7)     begin bad++; $display("FAIL toggle_4th_beat: got %0d required 7", last_bp_t); end
        total++; if (ben_t - last_bp_t !== 1) begin bad++; $display("FAIL toggle_ben_gap: got %0d required 1", ben_t - last_bp_t); end
    endtask

    task automatic test_zero_len();
        fill(0, 0);
        run_job(0, 1'b0, "zero");
        total++; if (n_bp !== 4)   begin bad++; $display("FAIL zero_bpe: got %0d required 4", n_bp); end
        total++; if (n_ben !== 1)  begin bad++; $display("FAIL zero_ben: got %0d required 1", n_ben); end
        total++; if (n_ir !== 0)   begin bad++; $display("FAIL zero_inp_ready: got %0d required 0", n_ir); end
        total++; if (n_ov !== 0)   begin bad++; $display("FAIL zero_out_valid: got %0d required 0", n_ov); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL zero_done: got %0d required 1", n_done); end
    endtask

    task automatic test_bubbles();
        // Weights take cycles 1..4, latch at 5, so streaming begins at cycle 6.
        fill(0, 1);
        iv[6] = 1'b1; iv[7] = 1'b0; iv[8] = 1'b0; iv[9] = 1'b1;
        run_job(2, 1'b0, "bubbles");
        total++; if (n_ov !== 2)               begin bad++; $display("FAIL bubbles_valids: got %0d required 2", n_ov); end
        total++; if (first_ov !== 6 + PL)      begin bad++; $display("FAIL bubbles_first: got %0d required %0d", first_ov, 6 + PL); end
        total++; if (last_ov - first_ov !== 3) begin bad++; $display("FAIL bubbles_gap: got %0d required 3", last_ov - first_ov); end
        total++; if (n_last !== 1 || last_t !== last_ov) begin
            bad++; $display("FAIL bubbles_last: got count %0d at %0d required 1 at %0d", n_last, last_t, last_ov);
        end
    endtask

    task automatic test_reset_mid();
        int rt;
        for (int r = 0; r < 2; r++) begin
            rt = (r == 0) ? 2 : 7;   // mid-load beat, then 2nd stream acceptance
            for (int t = 0; t <= rt + 14; t++) begin
                @(posedge clk); #1;
                start = (t == 0); k_len = 16'd3;
                bus.wgt_valid = 1'b1; bus.inp_valid = 1'b1;
                rst = (t == rt);
                @(negedge clk);
                if (t == rt) begin
                    total++;
                    if ((r == 0 ? bus.wgt_ready : bus.inp_ready) !== 1'b1) begin
                        bad++; $display("FAIL rstmid%0d_pre_ready: got 0 required 1", r);
                    end
                end else if (t == rt + 1) begin
                    total++;
                    if (snap() !== 14'd0) begin
                        bad++; $display("FAIL rstmid%0d_after: got %b required %b", r, snap(), 14'd0);
                    end
                end else if (t > rt + 1) begin
                    total++;
                    if ({busy, done, bus.out_valid, bus.out_last} !== 4'd0) begin
                        bad++; $display("FAIL rstmid%0d_quiet cycle%0d: got %b required 0000", r, t,
                                        {busy, done, bus.out_valid, bus.out_last});
                    end
                end
            end
            rst = 1'b0; start = 1'b0;
        end
        fill(0, 0);
        run_job(3, 1'b0, "post_rst");
        total++; if (n_ov !== 3 || n_done !== 1) begin
            bad++; $display("FAIL post_rst_job: got ov=%0d done=%0d required 3/1", n_ov, n_done);
        end
    endtask

    task automatic test_start_ignored();
        fill(0, 0);
        run_job(5, 1'b1, "spur_start");
        total++; if (n_acc !== 5)  begin bad++; $display("FAIL spur_accepts: got %0d required 5", n_acc); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL spur_done: got %0d required 1", n_done); end
    endtask

    task automatic test_random();
        int k;
        for (int j = 0; j < 8; j++) begin
            k = $urandom_range(0, 12);
            fill(2, 2);
            run_job(k, 1'b1, $sformatf("rand%0d_k%0d", j, k));
            total++;
            if (n_acc !== k || n_done !== 1) begin
                bad++; $display("FAIL rand%0d_counts: got acc=%0d done=%0d required %0d/1", j, n_acc, n_done, k);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; k_len = '0;
        bus.wgt_valid = 1'b0; bus.inp_valid = 1'b0;
        test_reset();
        test_full_job();
        test_wgt_toggle();
        test_zero_len();
        test_bubbles();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter ARRAY_M, default 32, PE rows (weight lanes, b_en/b_path_en width).
REQ-002 SHALL have parameter ARRAY_N, default 32, PE columns (weight beats per load).
REQ-003 SHALL have parameter LEN_WIDTH, default 16, width of k_len.
REQ-004 SHALL have parameter PIPE_LAT, default ARRAY_M+ARRAY_N, cycles from input-vector acceptance to result at array output.
REQ-005 Ports (one clock; reset is synchronous and active-high):
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin job; sampled only in IDLE
k_len  in  LEN_WIDTH  input vectors per job; captured on start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when job completes
wgt_valid  in  1  weight beat available
wgt_ready  out  1  weight beat accepted when valid&ready
b_path_en  out  ARRAY_M  weight shift enable, all bits equal
b_en  out  ARRAY_M  weight latch strobe, all bits equal
inp_valid  in  1  input vector available
inp_ready  out  1  input vector accepted when valid&ready
out_valid  out  1  array output carries a valid result this cycle
out_last  out  1  qualifies final out_valid of job

Function
REQ-006 FSM states IDLE, LOAD_W, LATCH_W, STREAM, DRAIN, FIN; reset state IDLE.
REQ-007 IDLE: start=1 -> capture k_len, clear counters, go LOAD_W; start in any other state ignored.
REQ-008 LOAD_W: wgt_ready=1; b_path_en all-ones exactly on cycles where wgt_valid&wgt_ready, else zero; wgt_valid=0 stalls with no shift.
REQ-009 LOAD_W counts accepted beats 0..ARRAY_N-1; on the ARRAY_N-th accepted beat go LATCH_W.
REQ-010 LATCH_W: b_en all-ones for exactly one cycle, wgt_ready=0; next state STREAM if captured k_len>0, else FIN.
REQ-011 STREAM: inp_ready=1; count accepted vectors; on the k_len-th acceptance go DRAIN; inp_valid=0 inserts a bubble (no count, no result tag).
REQ-012 Each accepted vector enters a PIPE_LAT-deep valid delay line; out_valid equals its output; bubbles enter as 0.
REQ-013 Last accepted vector carries a last tag in a parallel delay line; out_last = its output ANDed with out_valid.
REQ-014 DRAIN: inp_ready=0, wgt_ready=0; go FIN the cycle after out_last is 1.
REQ-015 FIN: done=1 for one cycle, then IDLE; start in FIN ignored.
REQ-016 k_len counter LEN_WIDTH bits, no wrap: maximum 2^LEN_WIDTH-1 vectors; beat counter $clog2(ARRAY_N)+1 bits.
REQ-017 wgt_ready and inp_ready SHALL never be high in the same cycle.
REQ-018 Outputs SHALL be registered or decoded from registered state only; no combinational path from wgt_valid/inp_valid to ready.

Reset
REQ-019 rst=1 at any state, mid-load or mid-stream: next cycle state IDLE, counters 0, delay lines cleared; pending results discarded.
REQ-020 Reset values: busy 0, done 0, wgt_ready 0, inp_ready 0, b_path_en 0, b_en 0, out_valid 0, out_last 0.

Structure
REQ-021 Shared package systolic_pkg SHALL hold the state enum type and the default-latency constant function (ARRAY_M+ARRAY_N).
REQ-022 One sub-module valid_delay_line (parameter DEPTH, 2-bit data: valid, last; synchronous reset) SHALL implement REQ-012/013.

Verification (ARRAY_M=ARRAY_N=4, PIPE_LAT=8)
REQ-023 start, k_len=3, wgt_valid and inp_valid held 1 -> b_path_en=4'hF 4 cycles, b_en=4'hF 1 cycle, 3 inp acceptances, out_valid 3 cycles starting 8 after first acceptance, out_last on 3rd, done 1 cycle later.
REQ-024 wgt_valid toggling 1,0,1,0... -> exactly 4 b_path_en pulses over 7 cycles, no pulse on idle cycles, b_en follows 4th beat by 1 cycle.
REQ-025 k_len=0 -> 4 weight beats, b_en pulse, FIN, done; inp_ready never 1, out_valid never 1.
REQ-026 k_len=2 with inp_valid 1,0,0,1 -> out_valid pattern 1,0,0,1 at PIPE_LAT offset; out_last on second valid only.
REQ-027 rst asserted on 2nd STREAM acceptance -> next cycle all outputs at REQ-020 values, no out_valid afterwards; new start runs a full clean job.
REQ-028 start pulsed during LOAD_W and FIN -> ignored; captured k_len unchanged, exactly one done per job.
